// File: rtl/video_sync_v_pkg.sv
// Shared vertical video timing: frame length, window bounds and display-mode helpers.
// Frame-buffer address logic imports the same numbers so both agree on line positions.
package video_sync_v_pkg;

  typedef logic [8:0] line_t;

  localparam line_t VPERIOD       = 9'd320;
  localparam line_t VLAST         = VPERIOD - 9'd1;
  localparam line_t VBLNK_BEG     = 9'd0;
  localparam line_t VSYNC_BEG     = 9'd8;
  localparam line_t VSYNC_END     = 9'd12;
  localparam line_t VBLNK_END     = 9'd32;
  localparam line_t VPIX_BEG_PENT = 9'd80;
  localparam line_t VPIX_END_PENT = 9'd272;
  localparam line_t VPIX_BEG_ATM  = 9'd76;
  localparam line_t VPIX_END_ATM  = 9'd276;
  localparam line_t VINT_BEG      = 9'd0;

  typedef enum logic {
    MODE_PENT = 1'b0,
    MODE_ATM  = 1'b1
  } vmode_e;

  function automatic line_t vpix_beg_for(input vmode_e mode);
    return (mode == MODE_ATM) ? VPIX_BEG_ATM : VPIX_BEG_PENT;
  endfunction

  function automatic line_t vpix_end_for(input vmode_e mode);
    return (mode == MODE_ATM) ? VPIX_END_ATM : VPIX_END_PENT;
  endfunction

endpackage

// File: rtl/video_sync_v_vwin.sv
// Generic set/clear window register: on a line event, sets at the set line and
// clears at the clear line (equality compares), otherwise holds.
module video_sync_v_vwin
  import video_sync_v_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  line_evt_i,
  input  line_t vcount_i,
  input  line_t set_line_i,
  input  line_t clr_line_i,
  output logic  win_o
);

  logic win_q, win_d;

  always_comb begin
    win_d = win_q;
    if (line_evt_i) begin
      if (vcount_i == set_line_i) begin
        win_d = 1'b1;
      end else if (vcount_i == clr_line_i) begin
        win_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= 1'b0;
    end else begin
      win_q <= win_d;
    end
  end

  assign win_o = win_q;

endmodule

// File: rtl/video_sync_v.sv
// Vertical timing generator: counts lines on hsync_start and produces vblank, vsync,
// the vertical pixel window and the frame_start / int_start strobes.
module video_sync_v
  import video_sync_v_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       hsync_start,
  input  logic       hint_start,
  input  logic       mode_atm_n_pent,
  output logic       vblank,
  output logic       vsync,
  output logic       vpix,
  output logic       frame_start,
  output logic       int_start,
  output logic [8:0] vcount
);

  line_t  vcount_q, vcount_d;
  vmode_e mode_q, mode_d;
  logic   frame_start_q, frame_start_d;
  logic   int_start_q, int_start_d;
  logic   wrap;
  line_t  vpix_beg, vpix_end;

  // init forces a wrap even when the counter is already at 0, so frame_start still pulses
  always_comb begin
    wrap          = init || (vcount_q == VLAST);
    vcount_d      = vcount_q;
    mode_d        = mode_q;
    frame_start_d = 1'b0;
    if (hsync_start) begin
      vcount_d      = wrap ? '0 : vcount_q + 9'd1;
      frame_start_d = wrap;
      if (wrap) begin
        mode_d = vmode_e'(mode_atm_n_pent);
      end
    end
    int_start_d = hint_start && (vcount_q == VINT_BEG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcount_q      <= '0;
      mode_q        <= MODE_PENT;
      frame_start_q <= 1'b0;
      int_start_q   <= 1'b0;
    end else begin
      vcount_q      <= vcount_d;
      mode_q        <= mode_d;
      frame_start_q <= frame_start_d;
      int_start_q   <= int_start_d;
    end
  end

  // The window picks its bounds from the latched mode, so a mid-frame flip waits for the wrap
  assign vpix_beg = vpix_beg_for(mode_q);
  assign vpix_end = vpix_end_for(mode_q);

  video_sync_v_vwin u_vblank (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_evt_i (hsync_start),
    .vcount_i   (vcount_q),
    .set_line_i (VBLNK_BEG),
    .clr_line_i (VBLNK_END),
    .win_o      (vblank)
  );

  video_sync_v_vwin u_vsync (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_evt_i (hsync_start),
    .vcount_i   (vcount_q),
    .set_line_i (VSYNC_BEG),
    .clr_line_i (VSYNC_END),
    .win_o      (vsync)
  );

  video_sync_v_vwin u_vpix (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_evt_i (hsync_start),
    .vcount_i   (vcount_q),
    .set_line_i (vpix_beg),
    .clr_line_i (vpix_end),
    .win_o      (vpix)
  );

  assign frame_start = frame_start_q;
  assign int_start   = int_start_q;
  assign vcount      = vcount_q;

endmodule

// File: tb/tb_video_sync_v.sv
// Self-checking bench for video_sync_v: randomized line gaps and hint positions
// checked in lockstep against a line-level reference model.
module tb_video_sync_v;

  localparam int VP = 320;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init = 1'b0;
  logic       hsync_start = 1'b0;
  logic       hint_start = 1'b0;
  logic       mode = 1'b0;
  logic       vblank, vsync, vpix, frame_start, int_start;
  logic [8:0] vcount;

  video_sync_v dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .init            (init),
    .hsync_start     (hsync_start),
    .hint_start      (hint_start),
    .mode_atm_n_pent (mode),
    .vblank          (vblank),
    .vsync           (vsync),
    .vpix            (vpix),
    .frame_start     (frame_start),
    .int_start       (int_start),
    .vcount          (vcount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_line;
  bit m_mode, m_blank, m_sync, m_pix, m_fs, m_int;

  int tick_err;
  logic [13:0] last_dut, last_exp;
  int cnt_blank, cnt_sync, cnt_pix, cnt_fs, cnt_int;

  logic [13:0] dut_vec;
  assign dut_vec = {vcount, vblank, vsync, vpix, frame_start, int_start};

  function automatic logic [13:0] mvec();
    logic [8:0] l;
    l = m_line[8:0];
    return {l, m_blank, m_sync, m_pix, m_fs, m_int};
  endfunction

  task automatic model_reset();
    m_line = 0; m_mode = 0; m_blank = 0; m_sync = 0; m_pix = 0; m_fs = 0; m_int = 0;
  endtask

  task automatic clr_counts();
    tick_err = 0; cnt_blank = 0; cnt_sync = 0; cnt_pix = 0; cnt_fs = 0; cnt_int = 0;
  endtask

  // One clock: drive inputs, advance the model by the frame rules, settle past the edge
  task automatic tick(input bit hs, input bit hint, input bit ini);
    int nxt;
    hsync_start = hs; hint_start = hint; init = ini;
    @(posedge clk);
    m_int = hint && (m_line == 0);
    m_fs  = 0;
    if (hs) begin
      nxt = (ini || m_line == VP - 1) ? 0 : m_line + 1;
      if (m_line == 0) m_blank = 1; else if (m_line == 32) m_blank = 0;
      if (m_line == 8) m_sync = 1; else if (m_line == 12) m_sync = 0;
      if (m_line == (m_mode ? 76 : 80)) m_pix = 1;
      else if (m_line == (m_mode ? 276 : 272)) m_pix = 0;
      if (nxt == 0) begin
        m_fs = 1;
        m_mode = mode;
      end
      m_line = nxt;
    end
    #1;
    hsync_start = 0; hint_start = 0; init = 0;
  endtask

  // One scan line: random idle clocks, then the hsync_start clock.
  // hint_sel: 0 none, 1 random clock within the line, 2 on the hsync clock.
  task automatic run_line(input int gap_max, input int hint_sel, input bit ini);
    int gap, hp;
    gap = $urandom_range(gap_max, 0);
    hp  = (hint_sel == 2) ? gap : $urandom_range(gap, 0);
    if (vblank) cnt_blank++;
    if (vsync) cnt_sync++;
    if (vpix) cnt_pix++;
    for (int t = 0; t <= gap; t++) begin
      tick(t == gap, (hint_sel != 0) && (t == hp), ini && (t == gap));
      if (dut_vec !== mvec()) begin
        tick_err++;
        last_dut = dut_vec;
        last_exp = mvec();
      end
      if (frame_start) cnt_fs++;
      if (int_start) cnt_int++;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    #3;
    rst_n = 1;
  endtask

  task automatic test_reset();
    model_reset();
    hsync_start = 1;
    #12;
    checks++;
    if (dut_vec !== 14'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec, 14'd0);
    end
    hsync_start = 0;
    rst_n = 1;
    #3;
  endtask

  task automatic test_count_frame();
    int vc_bad;
    mode = 0;
    do_reset();
    clr_counts();
    vc_bad = 0;
    for (int l = 0; l < VP; l++) begin
      if (vcount !== l[8:0]) vc_bad++;
      run_line(3, 1, 0);
    end
    checks++;
    if (vc_bad !== 0) begin failures++; $display("FAIL count_seq bad_lines=%0d exp=0", vc_bad); end
    checks++;
    if (vcount !== 9'd0) begin failures++; $display("FAIL count_wrap got=%0d exp=0", vcount); end
    checks++;
    if (frame_start !== 1'b1) begin failures++; $display("FAIL count_fs got=%b exp=1", frame_start); end
    checks++;
    if (cnt_fs !== 1) begin failures++; $display("FAIL count_fs_num got=%0d exp=1", cnt_fs); end
    checks++;
    if (cnt_blank !== 32) begin failures++; $display("FAIL vblank_lines got=%0d exp=32", cnt_blank); end
    checks++;
    if (cnt_sync !== 4) begin failures++; $display("FAIL vsync_lines got=%0d exp=4", cnt_sync); end
    checks++;
    if (cnt_pix !== 192) begin failures++; $display("FAIL vpix_pent_lines got=%0d exp=192", cnt_pix); end
    checks++;
    if (cnt_int !== 1) begin failures++; $display("FAIL int_per_frame got=%0d exp=1", cnt_int); end
    checks++;
    if (tick_err !== 0) begin
      failures++;
      $display("FAIL count_lockstep errs=%0d got=%h exp=%h", tick_err, last_dut, last_exp);
    end
  endtask

  task automatic test_atm_mode();
    int pix_a, pix_b, pix_c;
    mode = 1;
    do_reset();
    clr_counts();
    run_line(2, 0, 1);
    checks++;
    if (vcount !== 9'd0 || frame_start !== 1'b1) begin
      failures++;
      $display("FAIL init_at_zero got_vc=%0d got_fs=%b exp_vc=0 exp_fs=1", vcount, frame_start);
    end
    cnt_pix = 0;
    for (int l = 0; l < VP; l++) run_line(2, 1, 0);
    pix_a = cnt_pix; cnt_pix = 0;
    for (int l = 0; l < VP; l++) begin
      if (l == 150) mode = 0;
      run_line(2, 1, 0);
    end
    pix_b = cnt_pix; cnt_pix = 0;
    for (int l = 0; l < VP; l++) run_line(2, 1, 0);
    pix_c = cnt_pix;
    checks++;
    if (pix_a !== 200) begin failures++; $display("FAIL vpix_atm_lines got=%0d exp=200", pix_a); end
    checks++;
    if (pix_b !== 200) begin failures++; $display("FAIL vpix_flip_frame got=%0d exp=200", pix_b); end
    checks++;
    if (pix_c !== 192) begin failures++; $display("FAIL vpix_after_flip got=%0d exp=192", pix_c); end
    checks++;
    if (tick_err !== 0) begin
      failures++;
      $display("FAIL atm_lockstep errs=%0d got=%h exp=%h", tick_err, last_dut, last_exp);
    end
  endtask

  task automatic test_int_coincident();
    mode = 0;
    do_reset();
    clr_counts();
    for (int l = 0; l < VP - 1; l++) run_line(2, 0, 0);
    run_line(2, 2, 0);
    checks++;
    if (int_start !== 1'b0 || frame_start !== 1'b1) begin
      failures++;
      $display("FAIL int_at_319 got_int=%b got_fs=%b exp_int=0 exp_fs=1", int_start, frame_start);
    end
    run_line(2, 2, 0);
    checks++;
    if (int_start !== 1'b1 || vcount !== 9'd1) begin
      failures++;
      $display("FAIL int_at_0 got_int=%b got_vc=%0d exp_int=1 exp_vc=1", int_start, vcount);
    end
    checks++;
    if (tick_err !== 0) begin
      failures++;
      $display("FAIL int_lockstep errs=%0d got=%h exp=%h", tick_err, last_dut, last_exp);
    end
  endtask

  task automatic test_init();
    mode = 0;
    do_reset();
    clr_counts();
    for (int l = 0; l < 100; l++) run_line(2, 1, 0);
    run_line(2, 0, 1);
    checks++;
    if (vcount !== 9'd0 || frame_start !== 1'b1 || vblank !== 1'b0) begin
      failures++;
      $display("FAIL init_wrap got_vc=%0d fs=%b vb=%b exp_vc=0 fs=1 vb=0", vcount, frame_start, vblank);
    end
    run_line(2, 0, 0);
    checks++;
    if (vblank !== 1'b1 || vcount !== 9'd1) begin
      failures++;
      $display("FAIL init_vblank got_vb=%b vc=%0d exp_vb=1 vc=1", vblank, vcount);
    end
    checks++;
    if (tick_err !== 0) begin
      failures++;
      $display("FAIL init_lockstep errs=%0d got=%h exp=%h", tick_err, last_dut, last_exp);
    end
  endtask

  task automatic test_reset_mid();
    int pix_early;
    mode = 0;
    do_reset();
    clr_counts();
    for (int l = 0; l < 85; l++) run_line(2, 0, 0);
    checks++;
    if (vpix !== 1'b1 || vcount !== 9'd85) begin
      failures++;
      $display("FAIL pre_reset got_vpix=%b vc=%0d exp_vpix=1 vc=85", vpix, vcount);
    end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 14'd0) begin failures++; $display("FAIL async_reset got=%h exp=%h", dut_vec, 14'd0); end
    rst_n = 1;
    @(posedge clk);
    #1;
    pix_early = 0;
    for (int l = 0; l <= 80; l++) begin
      if (vpix !== 1'b0) pix_early++;
      run_line(2, 0, 0);
    end
    checks++;
    if (pix_early !== 0) begin failures++; $display("FAIL vpix_after_reset early=%0d exp=0", pix_early); end
    checks++;
    if (vpix !== 1'b1) begin failures++; $display("FAIL vpix_line80 got=%b exp=1", vpix); end
    checks++;
    if (tick_err !== 0) begin
      failures++;
      $display("FAIL rstmid_lockstep errs=%0d got=%h exp=%h", tick_err, last_dut, last_exp);
    end
  endtask

  task automatic test_back_to_back();
    mode = 1;
    do_reset();
    clr_counts();
    for (int l = 0; l < 2 * VP + 40; l++) begin
      if (l == 500) mode = $urandom_range(1, 0);
      run_line(0, $urandom_range(1, 0), ($urandom_range(199, 0) == 0));
    end
    checks++;
    if (tick_err !== 0) begin
      failures++;
      $display("FAIL b2b_lockstep errs=%0d got=%h exp=%h", tick_err, last_dut, last_exp);
    end
  endtask

  initial begin
    test_reset();
    test_count_frame();
    test_atm_mode();
    test_int_coincident();
    test_init();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
